// File: rtl/latch_bist.sv
// Built-in self-test for an external D latch: walks an 8-step drive table,
// compares the synchronized latch output after a settle window and logs mismatches.
module latch_bist #(
   parameter int unsigned SETTLE_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       latch_q,
   output logic       latch_d,
   output logic       latch_en,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [7:0] fail_mask,
   output logic [2:0] step
);

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      SAMPLE,
      FINISH
   } state_t;

   // Step tables, bit i = step i
   localparam logic [7:0] EN_TBL  = 8'b1001_0011;
   localparam logic [7:0] D_TBL   = 8'b1100_0110;
   localparam logic [7:0] EXP_TBL = 8'b1000_1110;
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic       start_q;
   logic       sync1_q, sync2_q;
   logic [3:0] cnt_q, cnt_d;
   logic       latch_d_q, latch_d_d;
   logic       latch_en_q, latch_en_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [3:0] err_q, err_d;
   logic [7:0] mask_q, mask_d;
   logic [2:0] step_q, step_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      latch_d_d  = latch_d_q;
      latch_en_d = latch_en_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      err_d      = err_q;
      mask_d     = mask_q;
      step_d     = step_q;
      unique case (state_q)
         IDLE: begin
            latch_d_d  = 1'b0;
            latch_en_d = 1'b0;
            if (start_q) begin
               state_d = DRIVE;
               step_d  = '0;
               err_d   = '0;
               mask_d  = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         DRIVE: begin
            latch_en_d = EN_TBL[step_q];
            latch_d_d  = D_TBL[step_q];
            cnt_d      = '0;
            state_d    = SETTLE;
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         SAMPLE: begin
            if (sync2_q != EXP_TBL[step_q]) begin
               mask_d[step_q] = 1'b1;
               if (err_q != 4'd15) begin
                  err_d = err_q + 4'd1;
               end
            end
            if (step_q == 3'd7) begin
               state_d = FINISH;
            end else begin
               step_d  = step_q + 3'd1;
               state_d = DRIVE;
            end
         end
         FINISH: begin
            done_d     = 1'b1;
            pass_d     = (err_q == 4'd0);
            busy_d     = 1'b0;
            latch_en_d = 1'b0;
            latch_d_d  = 1'b0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         start_q    <= 1'b0;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         cnt_q      <= '0;
         latch_d_q  <= 1'b0;
         latch_en_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= '0;
         mask_q     <= '0;
         step_q     <= '0;
      end else begin
         state_q    <= state_d;
         start_q    <= start;
         sync1_q    <= latch_q;
         sync2_q    <= sync1_q;
         cnt_q      <= cnt_d;
         latch_d_q  <= latch_d_d;
         latch_en_q <= latch_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         mask_q     <= mask_d;
         step_q     <= step_d;
      end
   end

   assign latch_d   = latch_d_q;
   assign latch_en  = latch_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_mask = mask_q;
   assign step      = step_q;

endmodule

// File: tb/tb_latch_bist.sv
// Directed bench for latch_bist: behavioural latch models with injected faults,
// table of full runs plus reset/abort and long-settle sequences.
module tb_latch_bist;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   int         mode = 0;

   logic       q1, d1, en1, busy1, done1, pass1;
   logic [3:0] err1;
   logic [7:0] mask1;
   logic [2:0] step1;
   logic       q2, d2, en2, busy2, done2, pass2;
   logic [3:0] err2;
   logic [7:0] mask2;
   logic [2:0] step2;
   logic       ideal1, ideal2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   latch_bist dut1 (
      .clk(clk), .rst(rst), .start(start), .latch_q(q1),
      .latch_d(d1), .latch_en(en1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_mask(mask1), .step(step1)
   );

   latch_bist #(.SETTLE_CYCLES(15)) dut2 (
      .clk(clk), .rst(rst), .start(start), .latch_q(q2),
      .latch_d(d2), .latch_en(en2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .fail_mask(mask2), .step(step2)
   );

   always_latch if (en1) ideal1 <= d1;
   always_latch if (en2) ideal2 <= d2;
   assign q2 = ideal2;

   // 0 ideal, 1 stuck-at-0, 2 transparent, 3 stuck-at-1, 4 inverting
   always_comb begin
      q1 = ideal1;
      case (mode)
         1: q1 = 1'b0;
         2: q1 = d1;
         3: q1 = 1'b1;
         4: q1 = ~d1;
         default: q1 = ideal1;
      endcase
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic run1(input bit restart, output int lat);
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin
            chk("busy_rise", busy1, 1);
            chk("done_clear", done1, 0);
         end
         if (restart && i == 10) start = 1'b1;
         if (restart && i == 11) start = 1'b0;
         if (done1) begin
            lat = i;
            break;
         end
      end
   endtask

   typedef struct {
      int mode;
      bit restart;
      int exp_pass;
      int exp_err;
      int exp_mask;
   } vec_t;

   vec_t vecs[6];
   int   lat;

   initial begin
      vecs[0] = '{mode: 0, restart: 1'b0, exp_pass: 1, exp_err: 0, exp_mask: 'h00};
      vecs[1] = '{mode: 1, restart: 1'b0, exp_pass: 0, exp_err: 4, exp_mask: 'h8E};
      vecs[2] = '{mode: 2, restart: 1'b0, exp_pass: 0, exp_err: 2, exp_mask: 'h48};
      vecs[3] = '{mode: 0, restart: 1'b1, exp_pass: 1, exp_err: 0, exp_mask: 'h00};
      vecs[4] = '{mode: 3, restart: 1'b0, exp_pass: 0, exp_err: 4, exp_mask: 'h71};
      vecs[5] = '{mode: 4, restart: 1'b0, exp_pass: 0, exp_err: 6, exp_mask: 'hB7};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_pass", pass1, 0);
      chk("rst_err", err1, 0);
      chk("rst_mask", mask1, 0);
      chk("rst_step", step1, 0);
      chk("rst_en", en1, 0);
      chk("rst_d", d1, 0);
      @(negedge clk); rst = 1'b0;

      for (int v = 0; v < 6; v++) begin
         mode = vecs[v].mode;
         run1(vecs[v].restart, lat);
         chk($sformatf("v%0d_latency", v), lat, 42);
         chk($sformatf("v%0d_busy_end", v), busy1, 0);
         chk($sformatf("v%0d_pass", v), pass1, vecs[v].exp_pass);
         chk($sformatf("v%0d_err", v), err1, vecs[v].exp_err);
         chk($sformatf("v%0d_mask", v), mask1, vecs[v].exp_mask);
         chk($sformatf("v%0d_en_end", v), en1, 0);
         repeat (5) @(posedge clk);
         #1;
         chk($sformatf("v%0d_done_hold", v), done1, 1);
         chk($sformatf("v%0d_pass_hold", v), pass1, vecs[v].exp_pass);
         chk($sformatf("v%0d_err_hold", v), err1, vecs[v].exp_err);
         chk($sformatf("v%0d_mask_hold", v), mask1, vecs[v].exp_mask);
         chk($sformatf("v%0d_idle_en", v), en1, 0);
         chk($sformatf("v%0d_idle_d", v), d1, 0);
      end

      // Abort mid-run: reset lands in the SETTLE phase of step 4 under a stuck-at-0 fault
      mode = 1;
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (step1 == 3'd4) begin
            lat = i;
            break;
         end
      end
      chk("abort_step4_reached", lat, 21);
      chk("abort_err_before", err1, 3);
      @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", busy1, 0);
      chk("abort_done", done1, 0);
      chk("abort_pass", pass1, 0);
      chk("abort_err", err1, 0);
      chk("abort_mask", mask1, 0);
      chk("abort_step", step1, 0);
      chk("abort_en", en1, 0);
      chk("abort_d", d1, 0);
      @(negedge clk); rst = 1'b0;
      mode = 0;
      run1(1'b0, lat);
      chk("post_abort_latency", lat, 42);
      chk("post_abort_pass", pass1, 1);
      chk("post_abort_err", err1, 0);
      chk("post_abort_mask", mask1, 0);

      // start coincident with reset is dropped
      @(negedge clk); rst = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk); rst = 1'b0; start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_start_busy", busy1, 0);
      chk("rst_start_done", done1, 0);
      chk("rst_start_en", en1, 0);

      // Long settle window on the second instance
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      begin
         int prev;
         int changes;
         int dlat;
         prev = 0;
         changes = 0;
         dlat = 0;
         for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (i == 1) chk("s15_busy_rise", busy2, 1);
            if (int'(step2) != prev) begin
               changes++;
               chk($sformatf("s15_step_val_%0d", changes), step2, prev + 1);
               chk($sformatf("s15_step_time_%0d", changes), i, 1 + 17 * (prev + 1));
               prev = int'(step2);
            end
            if (done2) begin
               dlat = i;
               break;
            end
         end
         chk("s15_changes", changes, 7);
         chk("s15_latency", dlat, 138);
         chk("s15_pass", pass2, 1);
         chk("s15_err", err2, 0);
         chk("s15_mask", mask2, 0);
         chk("s15_busy_end", busy2, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/latch_bist.md
LATCH_BIST -- requirements
Module: latch_bist

Interface
REQ-001 Parameter SETTLE_CYCLES, default 3: cycles waited after each drive before Q is compared; legal range 3..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 start  input  1  pulse; begins a self-test run when sampled high in IDLE.
REQ-005 latch_q  input  1  Q of the downstream D latch under test, asynchronous to clk.
REQ-006 latch_d  output  1  registered D drive to the latch.
REQ-007 latch_en  output  1  registered gate/enable drive to the latch.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  sticky run-complete flag.
REQ-010 pass  output  1  sticky; valid when done=1; 1 = zero mismatches.
REQ-011 err_count  output  4  mismatch count, saturating at 15.
REQ-012 fail_mask  output  8  bit i set = step i mismatched.
REQ-013 step  output  3  index of the step currently executing.

Function
REQ-014 latch_q SHALL pass through a 2-flop synchronizer; only the synchronized value is compared.
REQ-015 FSM states SHALL be IDLE, DRIVE, SETTLE, SAMPLE, FINISH.
REQ-016 IDLE: start=1 -> DRIVE, step=0, err_count=0, fail_mask=0, done=0, pass=0, busy=1; start=0 -> stay.
REQ-017 Step table (en,d -> expected q): 0:(1,0->0) 1:(1,1->1) 2:(0,1->1) 3:(0,0->1) 4:(1,0->0) 5:(0,0->0) 6:(0,1->0) 7:(1,1->1).
REQ-018 DRIVE (1 cycle): latch_en/latch_d loaded from the table entry for step, settle counter cleared -> SETTLE.
REQ-019 SETTLE: lasts exactly SETTLE_CYCLES cycles, latch_en/latch_d held -> SAMPLE.
REQ-020 SAMPLE (1 cycle): synchronized q compared to expected; on mismatch set fail_mask[step] and increment err_count unless it is already 15.
REQ-021 SAMPLE with step<7 -> DRIVE with step+1; step=7 -> FINISH.
REQ-022 FINISH (1 cycle): done=1, pass=(err_count==0 after the step-7 compare), busy=0, latch_en=0, latch_d=0 -> IDLE.
REQ-023 Latency: start sampled at edge N -> busy=1 after N+1; done=1 and busy=0 after edge N+1+8*(SETTLE_CYCLES+2)+1 (N+42 for default).
REQ-024 start while busy=1 SHALL be ignored; no restart, no counter change.
REQ-025 done/pass/err_count/fail_mask SHALL hold after FINISH until the next accepted start or rst.
REQ-026 In IDLE, latch_en=0, latch_d=0.
REQ-027 err_count SHALL never wrap; with 8 steps it cannot exceed 8, but the saturation logic is mandatory.

Reset
REQ-028 rst=1 at an edge SHALL force state IDLE and latch_d=0, latch_en=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, step=0, synchronizer flops=0.
REQ-029 rst during any state, including mid-run, SHALL abort the run with the REQ-028 values; rst has priority over start.
REQ-030 start sampled together with rst=1 SHALL be ignored.

Verification
REQ-031 Ideal latch model, SETTLE_CYCLES=3, start pulse -> done=1 at N+42, pass=1, err_count=0, fail_mask=8'h00.
REQ-032 latch_q stuck at 0 -> done=1, pass=0, err_count=4, fail_mask=8'h8E (steps 1,2,3,7).
REQ-033 Transparent-only model (q=d always) -> pass=0, err_count=2, fail_mask=8'h48 (steps 3,6).
REQ-034 Second start pulse 10 cycles into a run -> completion still at N+42, results identical to REQ-031.
REQ-035 rst asserted in SETTLE of step 4 -> next edge all outputs at REQ-028 values; a new start then gives the full REQ-031 result.
REQ-036 SETTLE_CYCLES=15, ideal model -> done at N+1+8*17+1 = N+138, pass=1; step trace 0..7, each value held 17 cycles.
